// File: rtl/multi_stream_engine.sv
// multi_stream_engine: N independent stream memories, each streamed to its PE
// port over valid/ready with a small prefetch FIFO hiding memory read latency.
// A shared IO port loads and reads back the memories while execution is off.
module multi_stream_engine #(
   parameter int N_STREAMS  = 8,
   parameter int ADDR_L     = 8,
   parameter int WORD_L     = 32,
   parameter int DATA_L     = 32,
   parameter int RD_LATENCY = 1,
   parameter int REPEAT_L   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_L-1:0]               wr_data_io,
   input  logic [ADDR_L-1:0]               addr_io,
   input  logic [$clog2(N_STREAMS)-1:0]    stream_id_io,
   input  logic                            wr_vld_io,
   input  logic                            rd_vld_io,
   output logic [DATA_L-1:0]               rd_data_io,
   output logic                            rd_data_vld_io,
   input  logic                            reset_execution_io,
   input  logic                            enable_execution_io,
   output logic                            done_execution_io,
   input  logic [N_STREAMS-1:0]            stream_en_io,
   input  logic [N_STREAMS*REPEAT_L-1:0]   repeat_io,
   input  logic [N_STREAMS*ADDR_L-1:0]     stream_start_addr_io,
   input  logic [N_STREAMS*ADDR_L-1:0]     stream_end_addr_io,
   output logic [N_STREAMS*WORD_L-1:0]     data_pe,
   output logic [N_STREAMS-1:0]            vld_pe,
   input  logic [N_STREAMS-1:0]            rdy_pe
);

   localparam int DEPTH      = 2**ADDR_L;
   localparam int FIFO_DEPTH = RD_LATENCY + 1;
   localparam int CNT_L      = $clog2(FIFO_DEPTH + 1);
   localparam int FP_L       = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   logic [WORD_L-1:0]       r_mem [N_STREAMS][DEPTH];
   logic [RD_LATENCY-1:0]   r_io_v;
   logic [WORD_L-1:0]       r_io_d [RD_LATENCY];
   logic [N_STREAMS-1:0]    w_done;
   logic                    w_unused_wr;

   assign w_unused_wr = ^wr_data_io;

   function automatic logic [FP_L-1:0] inc_ptr(input logic [FP_L-1:0] p);
      return (p == FP_L'(FIFO_DEPTH - 1)) ? '0 : p + FP_L'(1);
   endfunction

   // IO writes land only while execution is off; memory is never cleared
   always_ff @(posedge clk) begin
      if (wr_vld_io && !enable_execution_io)
         r_mem[stream_id_io][addr_io] <= wr_data_io[WORD_L-1:0];
   end

   // IO read data pipeline (memory latency stages)
   always_ff @(posedge clk) begin
      r_io_d[0] <= r_mem[stream_id_io][addr_io];
      for (int unsigned k = 1; k < RD_LATENCY; k++)
         r_io_d[k] <= r_io_d[k-1];
   end

   // IO read valid pipeline plus registered, zero-extended read output
   always_ff @(posedge clk) begin
      if (rst) begin
         r_io_v         <= '0;
         rd_data_vld_io <= 1'b0;
         rd_data_io     <= '0;
      end else begin
         r_io_v[0] <= rd_vld_io && !enable_execution_io;
         for (int unsigned k = 1; k < RD_LATENCY; k++)
            r_io_v[k] <= r_io_v[k-1];
         rd_data_vld_io <= r_io_v[RD_LATENCY-1];
         if (r_io_v[RD_LATENCY-1])
            rd_data_io <= DATA_L'(r_io_d[RD_LATENCY-1]);
      end
   end

   // Global done: registered AND of all per-stream DONE states
   always_ff @(posedge clk) begin
      if (rst || reset_execution_io)
         done_execution_io <= 1'b0;
      else
         done_execution_io <= &w_done;
   end

   for (genvar g = 0; g < N_STREAMS; g++) begin : g_stream
      state_t                r_state;
      logic [ADDR_L-1:0]     r_ptr;
      logic [REPEAT_L-1:0]   r_rep;
      logic [RD_LATENCY-1:0] r_pv;
      logic [WORD_L-1:0]     r_pd [RD_LATENCY];
      logic [WORD_L-1:0]     r_fifo [FIFO_DEPTH];
      logic [FP_L-1:0]       r_wp;
      logic [FP_L-1:0]       r_rp;
      logic [CNT_L-1:0]      r_cnt;
      logic [ADDR_L-1:0]     w_start;
      logic [ADDR_L-1:0]     w_end;
      logic [CNT_L:0]        w_outst;
      logic [CNT_L:0]        w_used;
      logic                  w_push;
      logic                  w_pop;
      logic                  w_issue;

      assign w_start = stream_start_addr_io[g*ADDR_L +: ADDR_L];
      assign w_end   = stream_end_addr_io[g*ADDR_L +: ADDR_L];
      assign vld_pe[g]                   = (r_cnt != '0);
      assign data_pe[g*WORD_L +: WORD_L] = r_fifo[r_rp];
      assign w_done[g]                   = (r_state == S_DONE);

      // Issue credit: in-flight reads plus FIFO occupancy, crediting a pop in
      // the same cycle so a full FIFO still sustains one word per cycle
      always_comb begin
         w_outst = '0;
         for (int unsigned k = 0; k < RD_LATENCY; k++)
            w_outst = w_outst + (CNT_L+1)'(r_pv[k]);
         w_push  = r_pv[RD_LATENCY-1];
         w_pop   = (r_cnt != '0) && rdy_pe[g];
         w_used  = w_outst + (CNT_L+1)'(r_cnt) - (CNT_L+1)'(w_pop);
         w_issue = (r_state == S_RUN) && enable_execution_io &&
                   (w_used < (CNT_L+1)'(FIFO_DEPTH));
      end

      // Stream read data pipeline and FIFO storage
      always_ff @(posedge clk) begin
         r_pd[0] <= r_mem[g][r_ptr];
         for (int unsigned k = 1; k < RD_LATENCY; k++)
            r_pd[k] <= r_pd[k-1];
         if (w_push)
            r_fifo[r_wp] <= r_pd[RD_LATENCY-1];
      end

      // Per-stream FSM, read pointer, repeat counter and FIFO bookkeeping
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rep   <= '0;
            r_pv    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
         end else if (reset_execution_io) begin
            r_state <= S_IDLE;
            r_ptr   <= w_start;
            r_rep   <= repeat_io[g*REPEAT_L +: REPEAT_L];
            r_pv    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
         end else begin
            r_pv[0] <= w_issue;
            for (int unsigned k = 1; k < RD_LATENCY; k++)
               r_pv[k] <= r_pv[k-1];
            if (w_push)
               r_wp <= inc_ptr(r_wp);
            if (w_pop)
               r_rp <= inc_ptr(r_rp);
            r_cnt <= r_cnt + CNT_L'(w_push) - CNT_L'(w_pop);

            case (r_state)
               S_IDLE: begin
                  // track configuration while idle so a plain rst also arms correctly
                  r_ptr <= w_start;
                  r_rep <= repeat_io[g*REPEAT_L +: REPEAT_L];
                  if (enable_execution_io)
                     r_state <= stream_en_io[g] ? S_RUN : S_DONE;
               end
               S_RUN: begin
                  if (w_issue) begin
                     if (r_ptr == w_end) begin
                        if (r_rep == '0) begin
                           r_state <= S_DRAIN;
                        end else begin
                           r_rep <= r_rep - REPEAT_L'(1);
                           r_ptr <= w_start;
                        end
                     end else begin
                        r_ptr <= r_ptr + ADDR_L'(1);
                     end
                  end
               end
               S_DRAIN: begin
                  if ((r_cnt == '0) && (w_outst == '0))
                     r_state <= S_DONE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
